conv_seq_ctrl: RTL and testbench

Sequencer for the streaming 3x3 convolution engine. It fetches an M×M image from a single-port pixel RAM and streams it into the engine once per kernel. Between passes it flushes the engine and selects the next kernel, and it collects exactly M×M results per kernel into the feature-map buffer. It sits between the top-level start/done handshake and the conv engine plus its memories.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_addr_gen.sv | 55 +++++
 rtl/conv_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_conv_seq_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer.
// Imported by conv_seq_ctrl and conv_addr_gen.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int CONV_IN_W  = 16;
  localparam int CONV_OUT_W = 32;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Pixel/result counters and result buffer address generation.
// Per-kernel base advances by M*M so no multiplier is needed.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int M      = 28,
  parameter int IMG_AW = 10,
  parameter int RES_AW = 12,
  parameter int CW     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_clr,
  input  logic              pass_clr,
  input  logic              rd_inc,
  input  logic              res_inc,
  input  logic              base_inc,
  output logic [IMG_AW-1:0] rd_cnt,
  output logic [CW-1:0]     res_cnt,
  output logic [RES_AW-1:0] res_wr_addr
);

  localparam int NPIX = M * M;

  logic [RES_AW-1:0] base;
  logic              res_full;

  assign res_full = (res_cnt == CW'(NPIX));

  always_ff @(posedge clk) begin
    if (reset) begin
      base        <= '0;
      rd_cnt      <= '0;
      res_cnt     <= '0;
      res_wr_addr <= '0;
    end else begin
      if (job_clr)
        base <= '0;
      else if (base_inc)
        base <= base + RES_AW'(NPIX);
      if (pass_clr) begin
        rd_cnt  <= '0;
        res_cnt <= '0;
      end else begin
        if (rd_inc)
          rd_cnt <= rd_cnt + IMG_AW'(1);
        if (res_inc && !res_full) begin
          res_wr_addr <= base + RES_AW'(res_cnt);
          res_cnt     <= res_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer: streams the image through the conv engine once per
// kernel, flushing between passes and collecting M*M results each.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter  int M           = 28,
  parameter  int NUM_KERNELS = 4,
  parameter  int FLUSH_CYC   = 2,
  parameter  int DRAIN_MAX   = 128,
  parameter  int IMG_AW      = $clog2(M * M),
  parameter  int RES_AW      = $clog2(NUM_KERNELS * M * M),
  localparam int KW          = cw(NUM_KERNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  img_rd_en,
  output logic [IMG_AW-1:0]     img_rd_addr,
  input  logic [CONV_IN_W-1:0]  img_rd_data,
  output logic [KW-1:0]         kernel_idx,
  output logic                  conv_rst,
  output logic [CONV_IN_W-1:0]  conv_pxl,
  output logic                  conv_valid,
  input  logic [CONV_OUT_W-1:0] conv_result,
  input  logic                  conv_result_valid,
  output logic                  res_wr_en,
  output logic [RES_AW-1:0]     res_wr_addr,
  output logic [CONV_OUT_W-1:0] res_wr_data
);

  localparam int NPIX = M * M;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int FW   = cw(FLUSH_CYC);
  localparam int DW   = cw(DRAIN_MAX);

  state_t state, nxt;

  logic [IMG_AW-1:0] rd_cnt;
  logic [CW-1:0]     res_cnt;
  logic [FW-1:0]     fcnt;
  logic [DW-1:0]     dcnt;
  logic              last_k;
  logic              res_full;
  logic              res_acc;
  logic              timeout;
  logic              pxl_sel;
  logic              vld_q;

  assign last_k   = (kernel_idx == KW'(NUM_KERNELS - 1));
  assign res_full = (res_cnt == CW'(NPIX));
  assign timeout  = (dcnt == DW'(DRAIN_MAX - 1));
  assign res_acc  = ((state == S_STREAM) || (state == S_DRAIN))
                    && conv_result_valid && !res_full;

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start) nxt = S_FLUSH;
      S_FLUSH:  if (fcnt == FW'(FLUSH_CYC - 1)) nxt = S_STREAM;
      S_STREAM: if (rd_cnt == IMG_AW'(NPIX - 1)) nxt = S_DRAIN;
      S_DRAIN:  if (res_full || timeout) nxt = S_NEXT;
      S_NEXT:   nxt = last_k ? S_DONE : S_FLUSH;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt        <= '0;
      dcnt        <= '0;
      kernel_idx  <= '0;
      error       <= 1'b0;
      pxl_sel     <= 1'b0;
      vld_q       <= 1'b0;
      res_wr_en   <= 1'b0;
      res_wr_data <= '0;
    end else begin
      fcnt <= (state == S_FLUSH) ? fcnt + FW'(1) : '0;
      dcnt <= (state == S_DRAIN) ? dcnt + DW'(1) : '0;
      if (state == S_IDLE && start) begin
        kernel_idx <= '0;
        error      <= 1'b0;
      end
      if (state == S_NEXT && !last_k)
        kernel_idx <= kernel_idx + KW'(1);
      if (state == S_DRAIN && timeout && !res_full)
        error <= 1'b1;
      // Valid stays up through DRAIN so the engine keeps shifting zeros
      pxl_sel   <= (state == S_STREAM);
      vld_q     <= (state == S_STREAM)
                   || (state == S_DRAIN && nxt == S_DRAIN);
      res_wr_en <= res_acc;
      if (res_acc)
        res_wr_data <= conv_result;
    end
  end

  conv_addr_gen #(
    .M      (M),
    .IMG_AW (IMG_AW),
    .RES_AW (RES_AW),
    .CW     (CW)
  ) u_addr (
    .clk         (clk),
    .reset       (reset),
    .job_clr     (state == S_IDLE && start),
    .pass_clr    (state == S_FLUSH),
    .rd_inc      (state == S_STREAM),
    .res_inc     (res_acc),
    .base_inc    (state == S_NEXT && !last_k),
    .rd_cnt      (rd_cnt),
    .res_cnt     (res_cnt),
    .res_wr_addr (res_wr_addr)
  );

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign conv_rst    = reset || (state == S_FLUSH);
  assign img_rd_en   = (state == S_STREAM);
  assign img_rd_addr = rd_cnt;
  assign conv_valid  = vld_q;
  assign conv_pxl    = pxl_sel ? img_rd_data : '0;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl with a pixel RAM and a
// behavioural conv engine that emits a limited number of results.
module tb_conv_seq_ctrl;

  localparam int M      = 28;
  localparam int NK     = 3;
  localparam int NPIX   = M * M;
  localparam int IMG_AW = 10;
  localparam int RES_AW = 12;
  localparam int KW     = 2;
  localparam int T_OK   = NK * (2 + NPIX + 4 + 1);
  localparam int T_TO   = NK * (2 + NPIX + 128 + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, error;
  logic              img_rd_en;
  logic [IMG_AW-1:0] img_rd_addr;
  logic [15:0]       img_rd_data = '0;
  logic [KW-1:0]     kernel_idx;
  logic              conv_rst;
  logic [15:0]       conv_pxl;
  logic              conv_valid;
  logic [31:0]       conv_result;
  logic              conv_result_valid;
  logic              res_wr_en;
  logic [RES_AW-1:0] res_wr_addr;
  logic [31:0]       res_wr_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [NPIX];

  logic        eng_v = 1'b0, p0v = 1'b0, p1v = 1'b0;
  logic [31:0] eng_d = '0, p0d = '0, p1d = '0;
  int          eng_n = 0;
  int          eng_lim = NPIX;
  logic        inj_v = 1'b0;

  int          exp_a [$];
  logic [31:0] exp_d [$];

  int busy_cyc, done_cnt, rst_cyc, pass_cnt;
  int rd_total, wr_total, max_wa;
  int rd_exp = 0;
  int prev_addr = 0;
  bit prev_rd = 0;

  always #5 clk = ~clk;

  assign conv_result_valid = eng_v | inj_v;
  assign conv_result       = inj_v ? 32'hDEAD_BEEF : eng_d;

  conv_seq_ctrl #(
    .M           (M),
    .NUM_KERNELS (NK),
    .FLUSH_CYC   (2),
    .DRAIN_MAX   (128),
    .IMG_AW      (IMG_AW),
    .RES_AW      (RES_AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .img_rd_en         (img_rd_en),
    .img_rd_addr       (img_rd_addr),
    .img_rd_data       (img_rd_data),
    .kernel_idx        (kernel_idx),
    .conv_rst          (conv_rst),
    .conv_pxl          (conv_pxl),
    .conv_valid        (conv_valid),
    .conv_result       (conv_result),
    .conv_result_valid (conv_result_valid),
    .res_wr_en         (res_wr_en),
    .res_wr_addr       (res_wr_addr),
    .res_wr_data       (res_wr_data)
  );

  // Single-port pixel RAM, one-cycle read latency
  always @(posedge clk)
    if (img_rd_en === 1'b1)
      img_rd_data <= mem[img_rd_addr];

  // Engine: 2-stage pipe, tags result with kernel, input index, pixel
  always @(negedge clk) begin
    if (conv_rst !== 1'b0) begin
      eng_n = 0;
      p0v = 0; p1v = 0; eng_v = 0;
    end else begin
      eng_v = p1v; eng_d = p1d;
      p1v = p0v; p1d = p0d;
      p0v = (conv_valid === 1'b1) && (eng_n < eng_lim);
      p0d = {6'(kernel_idx), 10'(eng_n), conv_pxl};
      if (conv_valid === 1'b1) eng_n++;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_rd = 0;
      rd_exp = 0;
    end else begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) done_cnt++;
      if (conv_rst === 1'b1 && busy === 1'b1) rst_cyc++;
      if (prev_rd) begin
        checks++;
        if (conv_valid !== 1'b1 || conv_pxl !== mem[prev_addr]) begin
          errors++;
          $display("FAIL pxl_lag: got v=%b p=%h expected v=1 p=%h",
                   conv_valid, conv_pxl, mem[prev_addr]);
        end
      end
      if (img_rd_en === 1'b1) begin
        checks++;
        if (img_rd_addr !== IMG_AW'(rd_exp)) begin
          errors++;
          $display("FAIL rd_addr: got %0d expected %0d",
                   img_rd_addr, rd_exp);
        end
        if (rd_exp == 0) begin
          checks++;
          if (kernel_idx !== KW'(pass_cnt)) begin
            errors++;
            $display("FAIL kernel_idx: got %0d expected %0d",
                     kernel_idx, pass_cnt);
          end
        end
        rd_total++;
        if (rd_exp == NPIX - 1) begin
          rd_exp = 0;
          pass_cnt++;
        end else begin
          rd_exp++;
        end
      end
      prev_rd = (img_rd_en === 1'b1);
      prev_addr = int'(img_rd_addr);
      if (res_wr_en === 1'b1) begin
        wr_total++;
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr: got addr %0d data %h expected none",
                   res_wr_addr, res_wr_data);
        end else begin
          int ea;
          logic [31:0] ed;
          ea = exp_a.pop_front();
          ed = exp_d.pop_front();
          if (res_wr_addr !== RES_AW'(ea) || res_wr_data !== ed) begin
            errors++;
            $display("FAIL wr: got %0d/%h expected %0d/%h",
                     res_wr_addr, res_wr_data, ea, ed);
          end
          if (int'(res_wr_addr) > max_wa) max_wa = int'(res_wr_addr);
        end
      end
    end
  end

  function automatic int nres(input int lim);
    return (lim < NPIX) ? lim : NPIX;
  endfunction

  task automatic start_job(input int lim, input bit hold);
    eng_lim = lim;
    for (int k = 0; k < NK; k++)
      for (int i = 0; i < nres(lim); i++) begin
        exp_a.push_back(k * NPIX + i);
        exp_d.push_back({6'(k), 10'(i), mem[i]});
      end
    busy_cyc = 0; done_cnt = 0; rst_cyc = 0; pass_cnt = 0;
    rd_total = 0; wr_total = 0; max_wa = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end
  endtask

  task automatic end_checks(input string nm, input int t_busy,
                            input logic e_err, input int lim);
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s_done_cnt: got %0d expected 1", nm, done_cnt);
    end
    checks++;
    if (busy_cyc != t_busy) begin
      errors++;
      $display("FAIL %s_busy_cyc: got %0d expected %0d",
               nm, busy_cyc, t_busy);
    end
    checks++;
    if (error !== e_err) begin
      errors++;
      $display("FAIL %s_error: got %b expected %b", nm, error, e_err);
    end
    checks++;
    if (exp_a.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_wr: got %0d left expected 0",
               nm, exp_a.size());
    end
    checks++;
    if (wr_total != NK * nres(lim) || rd_total != NK * NPIX) begin
      errors++;
      $display("FAIL %s_totals: got wr=%0d rd=%0d expected wr=%0d rd=%0d",
               nm, wr_total, rd_total, NK * nres(lim), NK * NPIX);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b expected 0", nm, busy);
    end
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic check_reset_vals(input string nm);
    checks++;
    if ({busy, done, error, img_rd_en, img_rd_addr, kernel_idx,
         conv_pxl, conv_valid, res_wr_en, res_wr_addr,
         res_wr_data} !== '0) begin
      errors++;
      $display("FAIL %s_outs: got b%b d%b e%b r%b a%0d k%0d p%h v%b w%b %0d %h expected all 0",
               nm, busy, done, error, img_rd_en, img_rd_addr, kernel_idx,
               conv_pxl, conv_valid, res_wr_en, res_wr_addr, res_wr_data);
    end
    checks++;
    if (conv_rst !== 1'b1) begin
      errors++;
      $display("FAIL %s_conv_rst: got %b expected 1", nm, conv_rst);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NPIX; i++) mem[i] = 16'(i * 37 + 5);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (conv_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rst=%b busy=%b expected 0 0",
               conv_rst, busy);
    end
  endtask

  task automatic test_basic();
    fill_pattern();
    start_job(NPIX, 0);
    checks++;
    if (busy !== 1'b1 || conv_rst !== 1'b1) begin
      errors++;
      $display("FAIL flush0: got busy=%b rst=%b expected 1 1", busy, conv_rst);
    end
    @(negedge clk);
    checks++;
    if (conv_rst !== 1'b1 || img_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL flush1: got rst=%b rd=%b expected 1 0", conv_rst, img_rd_en);
    end
    @(negedge clk);
    checks++;
    if (conv_rst !== 1'b0 || img_rd_en !== 1'b1 || conv_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream0: got rst=%b rd=%b v=%b expected 0 1 0",
               conv_rst, img_rd_en, conv_valid);
    end
    @(negedge clk);
    checks++;
    if (conv_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream1_valid: got %b expected 1", conv_valid);
    end
    wait_done("basic");
    checks++;
    if (max_wa != NK * NPIX - 1 || rst_cyc != 2 * NK) begin
      errors++;
      $display("FAIL basic_span: got max=%0d rst=%0d expected %0d %0d",
               max_wa, rst_cyc, NK * NPIX - 1, 2 * NK);
    end
    end_checks("basic", T_OK, 1'b0, NPIX);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < NPIX; i++) mem[i] = 16'h0001;
    start_job(NPIX, 0);
    wait_done("ones");
    checks++;
    if (rst_cyc != 2 * NK || pass_cnt != NK) begin
      errors++;
      $display("FAIL ones_passes: got rst=%0d pass=%0d expected %0d %0d",
               rst_cyc, pass_cnt, 2 * NK, NK);
    end
    end_checks("ones", T_OK, 1'b0, NPIX);
  endtask

  task automatic test_drain_timeout();
    fill_pattern();
    start_job(700, 0);
    wait_done("timeout");
    end_checks("timeout", T_TO, 1'b1, 700);
    start_job(NPIX, 0);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got %b expected 0", error);
    end
    wait_done("reclear");
    end_checks("reclear", T_OK, 1'b0, NPIX);
  endtask

  task automatic test_start_ignored();
    start_job(NPIX, 1);
    wait_done("held");
    start = 1'b0;
    end_checks("held", T_OK, 1'b0, NPIX);
    start_job(NPIX, 0);
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("pulse");
    end_checks("pulse", T_OK, 1'b0, NPIX);
  endtask

  task automatic test_reset_mid_drain();
    int n, dc;
    start_job(700, 0);
    n = 0;
    while (!(kernel_idx === 1 && img_rd_en === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    while (img_rd_en === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL mid_reach_drain: got timeout expected kernel 1 drain");
    end
    repeat (10) @(negedge clk);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    exp_a.delete();
    exp_d.delete();
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || conv_rst !== 1'b0 || done_cnt != dc) begin
      errors++;
      $display("FAIL mid_abort: got busy=%b rst=%b done=%0d expected 0 0 %0d",
               busy, conv_rst, done_cnt, dc);
    end
    start_job(NPIX, 0);
    wait_done("fresh");
    end_checks("fresh", T_OK, 1'b0, NPIX);
  endtask

  task automatic test_inject();
    for (int i = 0; i < 3; i++) begin
      inj_v = 1'b1;
      @(negedge clk);
      checks++;
      if (res_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL inj_idle: got %b expected 0", res_wr_en);
      end
    end
    inj_v = 1'b0;
    @(negedge clk);
    checks++;
    if (res_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL inj_idle_tail: got %b expected 0", res_wr_en);
    end
    start_job(NPIX, 0);
    inj_v = 1'b1;
    @(negedge clk);
    checks++;
    if (res_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL inj_flush0: got %b expected 0", res_wr_en);
    end
    inj_v = 1'b0;
    @(negedge clk);
    checks++;
    if (res_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL inj_flush1: got %b expected 0", res_wr_en);
    end
    wait_done("inject");
    end_checks("inject", T_OK, 1'b0, NPIX);
  endtask

  initial begin
    fill_pattern();
    test_reset();
    test_basic();
    test_all_ones();
    test_drain_timeout();
    test_start_ignored();
    fill_pattern();
    test_reset_mid_drain();
    test_inject();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
